playfield_lock: RTL and testbench

PLAYFIELD_LOCK -- requirements
Module: playfield_lock

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/playfield_lock_if.sv | 35 +++
 rtl/pix2cell.sv | 36 +++
 rtl/playfield_lock.sv | 216 +++++++++++++++++++++
 tb/tb_playfield_lock.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, FSM state encoding and score helper for the
// playfield lock/clear logic and the renderer.
package tetris_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int CELL      = 16;
  localparam int X_MIN     = 250;
  localparam int Y_MIN     = 100;
  localparam int SCORE_MAX = 9999;

  // Game state encoding on the state input that allows locking.
  localparam logic [1:0] GAME_PLAY = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } lock_state_t;

  // Increment a score, holding at the cap instead of wrapping.
  function automatic logic [13:0] score_inc(input logic [13:0] score,
                                            input logic [13:0] cap);
    logic [13:0] res;
    if (score >= cap) begin
      res = cap;
    end else begin
      res = score + 14'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/playfield_lock_if.sv
// Piece, status and draw-read signals between the game controller and the
// playfield. The controller is the master, the playfield the slave.
interface playfield_lock_if;

  logic [1:0]  state;
  logic        touching;
  logic [9:0]  shape_x;
  logic [9:0]  shape_y;
  logic [9:0]  shape_size_x;
  logic [9:0]  shape_size_y;
  logic [3:0]  rd_col;
  logic [4:0]  rd_row;
  logic        rd_cell;
  logic        stop_x_left;
  logic        stop_x_right;
  logic        shape_reset;
  logic        game_over;
  logic [13:0] Score;
  logic        busy;

  modport master (
    output state, touching, shape_x, shape_y, shape_size_x, shape_size_y,
           rd_col, rd_row,
    input  rd_cell, stop_x_left, stop_x_right, shape_reset, game_over,
           Score, busy
  );

  modport slave (
    input  state, touching, shape_x, shape_y, shape_size_x, shape_size_y,
           rd_col, rd_row,
    output rd_cell, stop_x_left, stop_x_right, shape_reset, game_over,
           Score, busy
  );

endinterface

// File: rtl/pix2cell.sv
// Pixel-to-cell conversion of the falling piece position and size.
// Positions left of / above the board wrap to large values and are then
// treated as off-board by the consumers.
module pix2cell
  import tetris_pkg::*;
#(
  parameter int ORIGIN_X = X_MIN,
  parameter int ORIGIN_Y = Y_MIN,
  parameter int PITCH    = CELL
) (
  input  logic [9:0] shape_x,
  input  logic [9:0] shape_y,
  input  logic [9:0] shape_size_x,
  input  logic [9:0] shape_size_y,
  output logic [5:0] col,
  output logic [5:0] row,
  output logic [5:0] w,
  output logic [5:0] h
);

  localparam int SH = $clog2(PITCH);

  logic [9:0] off_x_s;
  logic [9:0] off_y_s;

  // Offset from the board origin, then divide by the cell pitch.
  always_comb begin
    off_x_s = shape_x - 10'(ORIGIN_X);
    off_y_s = shape_y - 10'(ORIGIN_Y);
    col     = 6'(off_x_s >> SH);
    row     = 6'(off_y_s >> SH);
    w       = 6'(shape_size_x >> SH);
    h       = 6'(shape_size_y >> SH);
  end

endmodule

// File: rtl/playfield_lock.sv
// Playfield occupancy store: locks a landed piece into the board, clears
// full rows bottom-up with score counting, and reports top-out, lateral
// blocking and per-cell occupancy for drawing.
module playfield_lock #(
  parameter int COLS      = tetris_pkg::COLS,
  parameter int ROWS      = tetris_pkg::ROWS,
  parameter int CELL      = tetris_pkg::CELL,
  parameter int X_MIN     = tetris_pkg::X_MIN,
  parameter int Y_MIN     = tetris_pkg::Y_MIN,
  parameter int SCORE_MAX = tetris_pkg::SCORE_MAX
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic            game_reset,
  playfield_lock_if.slave pf
);

  import tetris_pkg::lock_state_t;
  import tetris_pkg::ST_IDLE;
  import tetris_pkg::ST_LOCK;
  import tetris_pkg::ST_SCAN;
  import tetris_pkg::ST_SHIFT;
  import tetris_pkg::ST_DONE;
  import tetris_pkg::GAME_PLAY;
  import tetris_pkg::score_inc;

  localparam int              RW        = $clog2(ROWS);
  localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);
  localparam logic [13:0]     SCORE_CAP = 14'(SCORE_MAX);

  lock_state_t state_r, state_nxt_s;

  logic [ROWS-1:0][COLS-1:0] board_r, board_nxt_s, lock_mask_s;
  logic [RW-1:0] scan_row_r, scan_row_nxt_s;
  logic [13:0]   score_r, score_nxt_s;
  logic [5:0]    cell_col_s, cell_row_s, cell_w_s, cell_h_s;
  logic [5:0]    col_r, row_r, w_r, h_r;
  logic          touch_r, touch_prev_r;
  logic          touch_rise_s, lock_start_s, row_full_s;
  logic          stop_left_s, stop_right_s, rd_cell_s;
  logic          shape_reset_r, game_over_r, busy_r;

  pix2cell #(
    .ORIGIN_X (X_MIN),
    .ORIGIN_Y (Y_MIN),
    .PITCH    (CELL)
  ) u_pix2cell (
    .shape_x      (pf.shape_x),
    .shape_y      (pf.shape_y),
    .shape_size_x (pf.shape_size_x),
    .shape_size_y (pf.shape_size_y),
    .col          (cell_col_s),
    .row          (cell_row_s),
    .w            (cell_w_s),
    .h            (cell_h_s)
  );

  // Rising-edge detector on touching; both stages are registered.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      touch_r      <= 1'b0;
      touch_prev_r <= 1'b0;
    end else begin
      touch_r      <= pf.touching;
      touch_prev_r <= touch_r;
    end
  end

  assign touch_rise_s = touch_r & ~touch_prev_r;
  assign lock_start_s = (state_r == ST_IDLE) && touch_rise_s && (pf.state == GAME_PLAY);
  assign row_full_s   = &board_r[scan_row_r];

  // Capture piece geometry when a lock is accepted; later moves are ignored.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      col_r <= 6'd0;
      row_r <= 6'd0;
      w_r   <= 6'd0;
      h_r   <= 6'd0;
    end else if (lock_start_s) begin
      col_r <= cell_col_s;
      row_r <= cell_row_s;
      w_r   <= cell_w_s;
      h_r   <= cell_h_s;
    end else begin
      col_r <= col_r;
      row_r <= row_r;
      w_r   <= w_r;
      h_r   <= h_r;
    end
  end

  // Cells covered by the captured piece, clipped to the board.
  always_comb begin
    lock_mask_s = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        lock_mask_s[i][j] = (i >= int'(row_r)) && (i < int'(row_r) + int'(h_r)) &&
                            (j >= int'(col_r)) && (j < int'(col_r) + int'(w_r));
      end
    end
  end

  // Lateral blocking from the live piece position against the board.
  always_comb begin
    stop_left_s  = (cell_col_s == 6'd0);
    stop_right_s = (int'(cell_col_s) + int'(cell_w_s) >= COLS);
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        stop_left_s  = stop_left_s |
                       (board_r[i][j] && (i >= int'(cell_row_s)) &&
                        (i < int'(cell_row_s) + int'(cell_h_s)) &&
                        (j + 1 == int'(cell_col_s)));
        stop_right_s = stop_right_s |
                       (board_r[i][j] && (i >= int'(cell_row_s)) &&
                        (i < int'(cell_row_s) + int'(cell_h_s)) &&
                        (j == int'(cell_col_s) + int'(cell_w_s)));
      end
    end
  end

  // Draw read port; anything outside the board reads as empty.
  always_comb begin
    rd_cell_s = 1'b0;
    if ((int'(pf.rd_row) < ROWS) && (int'(pf.rd_col) < COLS)) begin
      rd_cell_s = board_r[pf.rd_row][pf.rd_col];
    end else begin
      rd_cell_s = 1'b0;
    end
  end

  // Lock/scan/shift sequencing and the next board and score values.
  always_comb begin
    state_nxt_s    = state_r;
    scan_row_nxt_s = scan_row_r;
    board_nxt_s    = board_r;
    score_nxt_s    = score_r;
    case (state_r)
      ST_IDLE: begin
        if (lock_start_s) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCK: begin
        board_nxt_s    = board_r | lock_mask_s;
        scan_row_nxt_s = LAST_ROW;
        state_nxt_s    = ST_SCAN;
      end
      ST_SCAN: begin
        if (row_full_s) begin
          state_nxt_s = ST_SHIFT;
        end else if (scan_row_r == '0) begin
          state_nxt_s = ST_DONE;
        end else begin
          scan_row_nxt_s = scan_row_r - RW'(1);
          state_nxt_s    = ST_SCAN;
        end
      end
      ST_SHIFT: begin
        // Everything above the full row drops by one; the top row empties.
        board_nxt_s[0] = '0;
        for (int i = 1; i < ROWS; i++) begin
          board_nxt_s[i] = (i <= int'(scan_row_r)) ? board_r[i-1] : board_r[i];
        end
        score_nxt_s = score_inc(score_r, SCORE_CAP);
        state_nxt_s = ST_SCAN;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, board, score and status registers; game_reset aborts any operation.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      scan_row_r    <= '0;
      board_r       <= '0;
      score_r       <= 14'd0;
      shape_reset_r <= 1'b0;
      game_over_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else if (game_reset) begin
      state_r       <= ST_IDLE;
      scan_row_r    <= '0;
      board_r       <= '0;
      score_r       <= 14'd0;
      shape_reset_r <= 1'b0;
      game_over_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      scan_row_r    <= scan_row_nxt_s;
      board_r       <= board_nxt_s;
      score_r       <= score_nxt_s;
      shape_reset_r <= (state_nxt_s == ST_DONE);
      game_over_r   <= (state_nxt_s == ST_DONE) && (|board_nxt_s[0]);
      busy_r        <= (state_nxt_s != ST_IDLE);
    end
  end

  assign pf.rd_cell      = rd_cell_s;
  assign pf.stop_x_left  = stop_left_s;
  assign pf.stop_x_right = stop_right_s;
  assign pf.shape_reset  = shape_reset_r;
  assign pf.game_over    = game_over_r;
  assign pf.Score        = score_r;
  assign pf.busy         = busy_r;

endmodule

// File: tb/tb_playfield_lock.sv
// Directed bench for playfield_lock: locks pieces through the touching
// handshake and checks board contents, latency, score and status outputs.
module tb_playfield_lock;

  logic frame_clk = 1'b0;
  logic Reset;
  logic game_reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  playfield_lock_if pf ();

  playfield_lock dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .game_reset (game_reset),
    .pf         (pf)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge frame_clk);
  endtask

  task automatic set_piece(input int x, input int y, input int sx, input int sy);
    pf.shape_x      = 10'(x);
    pf.shape_y      = 10'(y);
    pf.shape_size_x = 10'(sx);
    pf.shape_size_y = 10'(sy);
  endtask

  // Lock a piece; lat is posedges from the touching sample edge to shape_reset (-1 on timeout).
  task automatic lock_piece(input int x, input int y, input int sx, input int sy,
                            output int lat, output logic go);
    set_piece(x, y, sx, sy);
    pf.touching = 1'b1;
    lat = -1;
    go  = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k == 1) pf.touching = 1'b0;
      if (pf.shape_reset) begin
        lat = k - 1;
        go  = pf.game_over;
        break;
      end
    end
  endtask

  task automatic read_row(input int r, output logic [9:0] v);
    v = '0;
    for (int c = 0; c < 10; c++) begin
      pf.rd_row = 5'(r);
      pf.rd_col = 4'(c);
      #1;
      v[c] = pf.rd_cell;
    end
  endtask

  task automatic board_count(output int n);
    logic [9:0] v;
    n = 0;
    for (int r = 0; r < 20; r++) begin
      read_row(r, v);
      n += $countones(v);
    end
  endtask

  task automatic pulse_game_reset();
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
    step();
  endtask

  initial begin
    int         lat;
    int         cnt;
    int         extra;
    logic       go;
    logic       seen;
    logic [9:0] v;

    Reset       = 1'b1;
    game_reset  = 1'b0;
    pf.state    = 2'd2;
    pf.touching = 1'b0;
    pf.rd_row   = 5'd0;
    pf.rd_col   = 4'd0;
    set_piece(0, 0, 0, 0);
    repeat (3) step();

    check_val("rst_busy", 32'(pf.busy), 32'd0);
    check_val("rst_score", 32'(pf.Score), 32'd0);
    check_val("rst_shape_reset", 32'(pf.shape_reset), 32'd0);
    check_val("rst_game_over", 32'(pf.game_over), 32'd0);
    board_count(cnt);
    check_val("rst_board", 32'(cnt), 32'd0);
    Reset = 1'b0;
    step();

    // Single lock on an empty board.
    lock_piece(298, 404, 32, 16, lat, go);
    check_val("t1_latency", 32'(lat), 32'd22);
    check_val("t1_game_over", 32'(go), 32'd0);
    step();
    check_val("t1_pulse_len", 32'(pf.shape_reset), 32'd0);
    read_row(19, v);
    check_val("t1_row19", 32'(v), 32'h018);
    board_count(cnt);
    check_val("t1_count", 32'(cnt), 32'd2);
    check_val("t1_score", 32'(pf.Score), 32'd0);
    check_val("t1_busy", 32'(pf.busy), 32'd0);

    // Lateral blocking against row 19 cols 3-4.
    set_piece(314, 404, 16, 16); #1;
    check_val("stop_l_col4", 32'(pf.stop_x_left), 32'd1);
    check_val("stop_r_col4", 32'(pf.stop_x_right), 32'd0);
    set_piece(250, 260, 16, 16); #1;
    check_val("stop_l_col0", 32'(pf.stop_x_left), 32'd1);
    check_val("stop_r_col0", 32'(pf.stop_x_right), 32'd0);
    set_piece(378, 260, 32, 16); #1;
    check_val("stop_l_col8", 32'(pf.stop_x_left), 32'd0);
    check_val("stop_r_col8", 32'(pf.stop_x_right), 32'd1);
    set_piece(282, 404, 16, 16); #1;
    check_val("stop_l_col2", 32'(pf.stop_x_left), 32'd0);
    check_val("stop_r_col2", 32'(pf.stop_x_right), 32'd1);

    // Read port range guard.
    pf.rd_row = 5'd19; pf.rd_col = 4'd3; #1;
    check_val("rd_in_range", 32'(pf.rd_cell), 32'd1);
    pf.rd_row = 5'd20; pf.rd_col = 4'd3; #1;
    check_val("rd_row_oor", 32'(pf.rd_cell), 32'd0);
    pf.rd_row = 5'd19; pf.rd_col = 4'd11; #1;
    check_val("rd_col_oor", 32'(pf.rd_cell), 32'd0);
    step();

    // Touching outside play state is ignored.
    pf.state = 2'd1;
    set_piece(250, 100, 16, 16);
    pf.touching = 1'b1;
    step();
    pf.touching = 1'b0;
    repeat (3) step();
    check_val("nplay_busy", 32'(pf.busy), 32'd0);
    repeat (30) step();
    board_count(cnt);
    check_val("nplay_count", 32'(cnt), 32'd2);
    pf.state = 2'd2;
    step();

    pulse_game_reset();
    board_count(cnt);
    check_val("greset_count", 32'(cnt), 32'd0);

    // One full row: row 19 cols 0-7 plus a marker in row 18, then fill cols 8-9.
    lock_piece(282, 388, 16, 16, lat, go);
    lock_piece(250, 404, 128, 16, lat, go);
    check_val("t2_pre_latency", 32'(lat), 32'd22);
    lock_piece(378, 404, 32, 16, lat, go);
    check_val("t2_latency", 32'(lat), 32'd24);
    check_val("t2_score", 32'(pf.Score), 32'd1);
    step();
    read_row(19, v);
    check_val("t2_row19", 32'(v), 32'h004);
    read_row(18, v);
    check_val("t2_row18", 32'(v), 32'h000);
    board_count(cnt);
    check_val("t2_count", 32'(cnt), 32'd1);

    pulse_game_reset();
    check_val("greset_score", 32'(pf.Score), 32'd0);

    // Two full rows cleared; markers in rows 16-17 drop by two.
    lock_piece(266, 388, 144, 32, lat, go);
    lock_piece(298, 372, 16, 16, lat, go);
    lock_piece(346, 356, 16, 16, lat, go);
    lock_piece(250, 388, 16, 32, lat, go);
    check_val("t3_latency", 32'(lat), 32'd26);
    check_val("t3_score", 32'(pf.Score), 32'd2);
    step();
    read_row(19, v);
    check_val("t3_row19", 32'(v), 32'h008);
    read_row(18, v);
    check_val("t3_row18", 32'(v), 32'h040);
    board_count(cnt);
    check_val("t3_count", 32'(cnt), 32'd2);

    pulse_game_reset();

    // Column 5 reaches the top row: game_over alongside shape_reset.
    lock_piece(330, 100, 16, 320, lat, go);
    check_val("t4_col_latency", 32'(lat), 32'd22);
    check_val("t4_col_game_over", 32'(go), 32'd1);
    lock_piece(250, 404, 16, 16, lat, go);
    check_val("t4_game_over", 32'(go), 32'd1);
    check_val("t4_shape_reset", 32'(pf.shape_reset), 32'd1);
    step();
    check_val("t4_go_pulse", 32'(pf.game_over), 32'd0);
    check_val("t4_score", 32'(pf.Score), 32'd0);

    pulse_game_reset();

    // A second touching edge while busy is dropped.
    set_piece(250, 404, 16, 16);
    pf.touching = 1'b1;
    step();
    pf.touching = 1'b0;
    repeat (4) step();
    check_val("drop_busy", 32'(pf.busy), 32'd1);
    pf.touching = 1'b1;
    step();
    pf.touching = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (pf.shape_reset) seen = 1'b1;
    end
    check_val("drop_first_done", 32'(seen), 32'd1);
    extra = 0;
    repeat (40) begin
      step();
      if (pf.shape_reset) extra++;
    end
    check_val("drop_no_second", 32'(extra), 32'd0);
    board_count(cnt);
    check_val("drop_count", 32'(cnt), 32'd1);

    pulse_game_reset();

    // Score saturation via full-board locks (20 clears each).
    for (int n = 0; n < 499; n++) begin
      lock_piece(250, 100, 160, 320, lat, go);
    end
    check_val("sat_full_latency", 32'(lat), 32'd62);
    check_val("sat_9980", 32'(pf.Score), 32'd9980);
    lock_piece(250, 116, 160, 304, lat, go);
    check_val("sat_9999", 32'(pf.Score), 32'd9999);
    lock_piece(250, 404, 160, 16, lat, go);
    check_val("sat_latency", 32'(lat), 32'd24);
    check_val("sat_hold", 32'(pf.Score), 32'd9999);
    step();
    board_count(cnt);
    check_val("sat_count", 32'(cnt), 32'd0);
    step();

    // game_reset while the first SHIFT is in progress.
    set_piece(250, 100, 160, 320);
    pf.touching = 1'b1;
    step();
    pf.touching = 1'b0;
    repeat (3) step();
    check_val("mid_busy", 32'(pf.busy), 32'd1);
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
    check_val("mid_score", 32'(pf.Score), 32'd0);
    check_val("mid_busy_clr", 32'(pf.busy), 32'd0);
    board_count(cnt);
    check_val("mid_count", 32'(cnt), 32'd0);
    extra = 0;
    repeat (70) begin
      step();
      if (pf.shape_reset) extra++;
    end
    check_val("mid_no_done", 32'(extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
